// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Program-counter sequencer. Chooses the next PC from
//               sequential, redirect (jump/branch), pending redirect, stall
//               and imem-wait sources, and drives IF/ID write/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        imem_ack_i,
  input  logic        loaduse_hazard_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        imem_req_o,
  output logic        fetch_err_o,
  output logic [15:0] stall_cycles_o
);

  localparam logic [1:0]  c_boot      = 2'd0;
  localparam logic [1:0]  c_fetch     = 2'd1;
  localparam logic [1:0]  c_error     = 2'd2;
  localparam logic [7:0]  c_wait_last = 8'(TIMEOUT - 1);
  localparam logic [15:0] c_stall_max = 16'hFFFF;

  logic [1:0]  r_state;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;

  logic        w_redirect;
  logic [31:0] w_redirect_tgt;

  // Jump wins over branch whenever both are raised in the same cycle.
  assign w_redirect     = jump_i | branch_taken_i;
  assign w_redirect_tgt = jump_i ? jump_target_i : branch_target_i;

  // Output decode: purely combinational from state, pending redirect and inputs.
  always_comb begin
    pc_next_o    = pc_i;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    imem_req_o   = 1'b0;
    if (!start_i) begin
      pc_next_o    = RESET_VECTOR;
      ifid_flush_o = 1'b1;
    end else begin
      case (r_state)
        c_boot: begin
          pc_next_o    = RESET_VECTOR;
          pc_write_o   = 1'b1;
          ifid_flush_o = 1'b1;
        end
        c_fetch: begin
          imem_req_o = 1'b1;
          if (!imem_ack_i || loaduse_hazard_i) begin
            // waiting on imem or stalled by hazard: hold PC and IF/ID
          end else if (jump_i) begin
            pc_next_o    = jump_target_i;
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else if (branch_taken_i) begin
            pc_next_o    = branch_target_i;
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else if (r_pend_valid) begin
            pc_next_o    = r_pend_target;
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else begin
            pc_next_o    = pc_i + 32'd4;
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
        end
        default: begin
          // error (and any unreachable encoding): freeze fetch, bubble IF/ID
          ifid_flush_o = 1'b1;
        end
      endcase
    end
  end

  // Sticky error flag follows the error state, which only reset leaves.
  assign fetch_err_o    = (r_state == c_error);
  assign stall_cycles_o = r_stall_cnt;

  // State, pending-redirect capture during imem wait, and imem timeout watch.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_state       <= c_boot;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
      r_wait_cnt    <= 8'h0;
    end else begin
      case (r_state)
        c_boot: r_state <= c_fetch;
        c_fetch: begin
          if (!imem_ack_i) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            // Keep only the first redirect seen during a wait.
            if (!loaduse_hazard_i && !r_pend_valid && w_redirect) begin
              r_pend_valid  <= 1'b1;
              r_pend_target <= w_redirect_tgt;
            end
            if (r_wait_cnt == c_wait_last) begin
              r_state <= c_error;
            end
          end else begin
            r_wait_cnt   <= 8'h0;
            r_pend_valid <= 1'b0;
          end
        end
        default: r_state <= c_error;
      endcase
    end
  end

  // Saturating count of FETCH cycles in which the PC was held.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_stall_cnt <= 16'h0;
    end else if (r_state == c_fetch && !pc_write_o && r_stall_cnt != c_stall_max) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Scoreboard testbench for pc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

  typedef logic [36:0] vec_t;  // {pc_next, pc_write, ifid_write, flush, req, err}

  logic        clk_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        imem_ack_i = 1'b0;
  logic        loaduse_hazard_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = 32'h0;
  logic [31:0] pc_next_o;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, imem_req_o, fetch_err_o;
  logic [15:0] stall_cycles_o;

  int   n_run  = 0;
  int   n_fail = 0;
  vec_t sb_exp[$];
  vec_t sb_obs[$];

  pc_ctrl #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .start_i(start_i), .pc_i(pc_i), .imem_ack_i(imem_ack_i),
    .loaduse_hazard_i(loaduse_hazard_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .pc_next_o(pc_next_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .imem_req_o(imem_req_o), .fetch_err_o(fetch_err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic [31:0] nx, input logic wr, iw, fl, rq, er);
    return {nx, wr, iw, fl, rq, er};
  endfunction

  // Drive one cycle of stimulus, record expected and observed outputs.
  task automatic step(input logic st, input logic [31:0] pc, input logic ack, hz,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input vec_t e);
    start_i = st; pc_i = pc; imem_ack_i = ack; loaduse_hazard_i = hz;
    branch_taken_i = br; branch_target_i = bt; jump_i = j; jump_target_i = jt;
    sb_exp.push_back(e);
    @(negedge clk_i);
    sb_obs.push_back({pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, imem_req_o, fetch_err_o});
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    vec_t e, o;
    step(0, 32'h10, 1, 0, 1, 32'h80, 1, 32'h90, mk(32'h0, 0, 0, 1, 0, 0));
    step(0, 32'h10, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'h0, 0, 0, 1, 0, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset: got %h expected %h", o, e); end
    end
    n_run++;
    if (stall_cycles_o !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles_o); end
  endtask

  task automatic test_sequential;
    vec_t e, o;
    step(1, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'h0, 1, 0, 1, 0, 0));   // BOOT
    step(1, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'h4, 1, 1, 0, 1, 0));
    step(1, 32'h4, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'h8, 1, 1, 0, 1, 0));
    step(1, 32'h8, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'hC, 1, 1, 0, 1, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL sequential: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_branch;
    vec_t e, o;
    step(1, 32'h100, 1, 0, 1, 32'h200, 0, 32'h0, mk(32'h200, 1, 0, 1, 1, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL branch: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_wait_jump;
    vec_t e, o;
    step(1, 32'h200, 0, 0, 0, 32'h0,  1, 32'h40, mk(32'h200, 0, 0, 0, 1, 0));
    step(1, 32'h200, 0, 0, 1, 32'h80, 0, 32'h0,  mk(32'h200, 0, 0, 0, 1, 0));
    step(1, 32'h200, 0, 0, 0, 32'h0,  0, 32'h0,  mk(32'h200, 0, 0, 0, 1, 0));
    step(1, 32'h200, 1, 0, 0, 32'h0,  0, 32'h0,  mk(32'h40, 1, 0, 1, 1, 0));
    n_run++;
    if (stall_cycles_o !== 16'd3) begin n_fail++; $display("FAIL wait_stall: got %0d expected 3", stall_cycles_o); end
    step(1, 32'h40, 1, 0, 0, 32'h0, 0, 32'h0, mk(32'h44, 1, 1, 0, 1, 0));   // pending cleared
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL wait_jump: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_loaduse;
    vec_t e, o;
    step(1, 32'h44, 1, 1, 1, 32'h300, 0, 32'h0,   mk(32'h44, 0, 0, 0, 1, 0));
    step(1, 32'h44, 1, 0, 0, 32'h0,   0, 32'h0,   mk(32'h48, 1, 1, 0, 1, 0));
    step(1, 32'h48, 0, 1, 0, 32'h0,   1, 32'h500, mk(32'h48, 0, 0, 0, 1, 0));
    step(1, 32'h48, 1, 0, 0, 32'h0,   0, 32'h0,   mk(32'h4C, 1, 1, 0, 1, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL loaduse: got %h expected %h", o, e); end
    end
    n_run++;
    if (stall_cycles_o !== 16'd5) begin n_fail++; $display("FAIL loaduse_stall: got %0d expected 5", stall_cycles_o); end
  endtask

  task automatic test_wrap_priority;
    vec_t e, o;
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,   0, 32'h0,   mk(32'h0,   1, 1, 0, 1, 0));
    step(1, 32'h0,         1, 0, 1, 32'h80,  1, 32'h40,  mk(32'h40,  1, 0, 1, 1, 0));
    step(1, 32'h4,         0, 0, 1, 32'h800, 1, 32'h700, mk(32'h4,   0, 0, 0, 1, 0));
    step(1, 32'h4,         1, 0, 0, 32'h0,   0, 32'h0,   mk(32'h700, 1, 0, 1, 1, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_priority: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_timeout;
    vec_t e, o;
    for (int i = 0; i < 16; i++)
      step(1, 32'h700, 0, 0, 0, 32'h0, 0, 32'h0, mk(32'h700, 0, 0, 0, 1, 0));
    step(1, 32'h700, 1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h700, 0, 0, 1, 0, 1));
    step(1, 32'h700, 1, 0, 0, 32'h0, 1, 32'h900, mk(32'h700, 0, 0, 1, 0, 1));
    n_run++;
    if (stall_cycles_o !== 16'd22) begin n_fail++; $display("FAIL timeout_stall: got %0d expected 22", stall_cycles_o); end
    step(0, 32'h700, 1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h0,   0, 0, 1, 0, 1));
    step(1, 32'h700, 1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h0,   1, 0, 1, 0, 0));   // BOOT
    step(1, 32'h0,   1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h4,   1, 1, 0, 1, 0));
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL timeout: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_midfetch;
    vec_t e, o;
    step(1, 32'h4, 0, 0, 0, 32'h0, 1, 32'h600, mk(32'h4, 0, 0, 0, 1, 0));
    step(0, 32'h4, 0, 0, 0, 32'h0, 0, 32'h0,   mk(32'h0, 0, 0, 1, 0, 0));
    step(1, 32'h4, 1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h0, 1, 0, 1, 0, 0));   // BOOT
    step(1, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0,   mk(32'h4, 1, 1, 0, 1, 0));   // pending discarded
    while (sb_exp.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset_midfetch: got %h expected %h", o, e); end
    end
    n_run++;
    if (stall_cycles_o !== 16'd0) begin n_fail++; $display("FAIL midfetch_stall: got %0d expected 0", stall_cycles_o); end
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_wait_jump();
    test_loaduse();
    test_wrap_priority();
    test_timeout();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
